// File: rtl/mc_control_fsm_if.sv
// Control bundle between the instruction register fields and the datapath.
// The FSM side (master) reads the instruction fields and drives every
// control line; the datapath/condition-logic side (slave) does the reverse.
interface mc_control_fsm_if;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic       PCS;
  logic       RegW;
  logic       MemW;
  logic [1:0] FlagW;
  logic       NoWrite;
  logic       NextPC;
  logic       IRWrite;
  logic       AdrSrc;
  logic [1:0] ResultSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUControl;
  logic [1:0] ImmSrc;
  logic [1:0] RegSrc;

  modport master (
    input  Op, Funct, Rd,
    output PCS, RegW, MemW, FlagW, NoWrite, NextPC, IRWrite, AdrSrc,
           ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc
  );

  modport slave (
    output Op, Funct, Rd,
    input  PCS, RegW, MemW, FlagW, NoWrite, NextPC, IRWrite, AdrSrc,
           ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle control unit for the ARM-subset CPU: main sequencing FSM plus
// the instruction/ALU decode. Write enables leave here raw; the conditional
// execution logic downstream gates them with the condition check.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// FETCH    | read instruction at PC, load IR, PC <= PC + 4
// DECODE   | read register file, precompute PC + 8 for branch/R15 use
// MEMADR   | compute load/store address (base + ExtImm)
// MEMRD    | read data memory at computed address
// MEMWB    | write loaded data back to Rd
// MEMWR    | write register B to data memory
// EXECUTER | data-processing op, register second operand
// EXECUTEI | data-processing op, immediate second operand
// ALUWB    | write ALU result back to Rd (suppressed downstream for CMP)
// BRANCH   | PC <= PC + 8 + offset
module mc_control_fsm #(
  parameter int STATE_W = 4
) (
  input  logic          clk,
  input  logic          reset,
  mc_control_fsm_if.master bus
);

  typedef enum logic [STATE_W-1:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_BRANCH
  } state_t;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  state_t state, state_nxt;

  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic [3:0] cmd;
  logic       s_bit;

  assign op    = bus.Op;
  assign funct = bus.Funct;
  assign rd    = bus.Rd;
  assign cmd   = funct[4:1];
  assign s_bit = funct[0];

  logic       branch;
  logic       alu_dec;
  logic       regw;
  logic       memw;
  logic       nextpc;
  logic       irwrite;
  logic       adrsrc;
  logic [1:0] resultsrc;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] aluctl;
  logic [1:0] flagw;
  logic       nowrite;

  // State register; reset aborts any instruction in flight and refetches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nxt;
  end

  // Next-state sequencing; illegal opcodes and unused encodings refetch.
  always_comb begin
    state_nxt = S_FETCH;
    case (state)
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: begin
        case (op)
          2'b00:   state_nxt = funct[5] ? S_EXECUTEI : S_EXECUTER;
          2'b01:   state_nxt = S_MEMADR;
          2'b10:   state_nxt = S_BRANCH;
          default: state_nxt = S_FETCH;
        endcase
      end
      S_MEMADR:   state_nxt = funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:    state_nxt = S_MEMWB;
      S_EXECUTER: state_nxt = S_ALUWB;
      S_EXECUTEI: state_nxt = S_ALUWB;
      default:    state_nxt = S_FETCH;
    endcase
  end

  // Moore control decode per state, then ALU/flag decode in execute states.
  always_comb begin
    branch    = 1'b0;
    alu_dec   = 1'b0;
    regw      = 1'b0;
    memw      = 1'b0;
    nextpc    = 1'b0;
    irwrite   = 1'b0;
    adrsrc    = 1'b0;
    resultsrc = 2'b00;
    alusrca   = 1'b0;
    alusrcb   = 2'b00;
    aluctl    = 2'b00;
    flagw     = 2'b00;
    nowrite   = 1'b0;

    case (state)
      S_FETCH: begin
        irwrite   = 1'b1;
        nextpc    = 1'b1;
        alusrca   = 1'b1;
        alusrcb   = 2'b10;
        resultsrc = 2'b10;
      end
      S_DECODE: begin
        alusrca   = 1'b1;
        alusrcb   = 2'b10;
        resultsrc = 2'b10;
      end
      S_MEMADR: alusrcb = 2'b01;
      S_MEMRD:  adrsrc  = 1'b1;
      S_MEMWB: begin
        resultsrc = 2'b01;
        regw      = 1'b1;
      end
      S_MEMWR: begin
        adrsrc = 1'b1;
        memw   = 1'b1;
      end
      S_EXECUTER: begin
        alusrcb = 2'b00;
        alu_dec = 1'b1;
      end
      S_EXECUTEI: begin
        alusrcb = 2'b01;
        alu_dec = 1'b1;
      end
      S_ALUWB: begin
        resultsrc = 2'b00;
        regw      = 1'b1;
        // Keep CMP's suppression visible through writeback, where it matters.
        nowrite   = (cmd == CMD_CMP);
      end
      S_BRANCH: begin
        alusrcb   = 2'b01;
        resultsrc = 2'b10;
        branch    = 1'b1;
      end
      default: ;
    endcase

    if (alu_dec) begin
      case (cmd)
        CMD_ADD: begin
          aluctl = 2'b00;
          flagw  = {s_bit, s_bit};
        end
        CMD_SUB: begin
          aluctl = 2'b01;
          flagw  = {s_bit, s_bit};
        end
        CMD_AND: begin
          aluctl = 2'b10;
          flagw  = {s_bit, 1'b0};
        end
        CMD_ORR: begin
          aluctl = 2'b11;
          flagw  = {s_bit, 1'b0};
        end
        CMD_CMP: begin
          aluctl  = 2'b01;
          flagw   = 2'b11;
          nowrite = 1'b1;
        end
        default: begin
          aluctl = 2'b00;
          flagw  = 2'b00;
        end
      endcase
    end
  end

  assign bus.PCS        = branch | (regw & (rd == 4'hF));
  assign bus.RegW       = regw;
  assign bus.MemW       = memw;
  assign bus.FlagW      = flagw;
  assign bus.NoWrite    = nowrite;
  assign bus.NextPC     = nextpc;
  assign bus.IRWrite    = irwrite;
  assign bus.AdrSrc     = adrsrc;
  assign bus.ResultSrc  = resultsrc;
  assign bus.ALUSrcA    = alusrca;
  assign bus.ALUSrcB    = alusrcb;
  assign bus.ALUControl = aluctl;
  assign bus.ImmSrc     = op;
  assign bus.RegSrc     = {(op == 2'b01), (op == 2'b10)};

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multicycle control unit for the ARM-subset CPU: instruction decoder plus main state machine.
- Generates the raw write-enables (PCS, RegW, MemW, FlagW, NoWrite) that the conditional-execution logic gates with the condition check.
- Also generates all datapath mux selects and the ALU command.
- Sits between the instruction register fields (Op, Funct, Rd) and the condition/flag logic.

Parameters:
STATE_W, 4, width of the state register (10 states used; must be >= 4).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
Op  in  2  instruction bits [27:26]
Funct  in  6  instruction bits [25:20]
Rd  in  4  destination register field
PCS  out  1  PC-write request (branch, or register write to R15)
RegW  out  1  register-file write request
MemW  out  1  data-memory write request
FlagW  out  2  flag-write request; [1]=N,Z, [0]=C,V
NoWrite  out  1  suppress register write (CMP)
NextPC  out  1  unconditional PC update (fetch)
IRWrite  out  1  instruction-register load
AdrSrc  out  1  memory address select (0=PC, 1=ALU result)
ResultSrc  out  2  result mux select (00=ALUOut, 01=Data, 10=ALUResult)
ALUSrcA  out  1  0=register A, 1=PC
ALUSrcB  out  2  00=register B, 01=ExtImm, 10=constant 4
ALUControl  out  2  00=ADD, 01=SUB, 10=AND, 11=ORR
ImmSrc  out  2  immediate extension select; equals Op
RegSrc  out  2  [0]=(Op==10), [1]=(Op==01)

Behaviour:
- One clock. Reset is asynchronous and active-high: reset forces the state to FETCH immediately.
- Outputs are Moore decodes of the state, except ImmSrc, RegSrc, PCS, ALUControl, FlagW and NoWrite, which also use Op, Funct and Rd.
- While reset is high, outputs hold the FETCH values:
  - IRWrite=1, NextPC=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALUControl=00.
  - All write requests = 0.
- Transitions, one per clock:
  - FETCH -> DECODE.
  - DECODE:
    - Op=01 -> MEMADR.
    - Op=00 with Funct[5]=0 -> EXECUTER.
    - Op=00 with Funct[5]=1 -> EXECUTEI.
    - Op=10 -> BRANCH.
    - Op=11 (illegal) -> FETCH, with no write asserted.
  - MEMADR: Funct[0]=1 -> MEMRD; otherwise -> MEMWR.
  - MEMRD -> MEMWB -> FETCH.
  - MEMWR -> FETCH.
  - EXECUTER and EXECUTEI -> ALUWB -> FETCH.
  - BRANCH -> FETCH.
  - Any unused encoding -> FETCH.
- State outputs (signals not listed are 0):
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcB=01.
  - MEMRD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWR: AdrSrc=1, MemW=1.
  - EXECUTER: ALUSrcB=00, ALU decode enabled.
  - EXECUTEI: ALUSrcB=01, ALU decode enabled.
  - ALUWB: ResultSrc=00, RegW=1.
  - BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1.
- PCS = Branch | (RegW & Rd==4'hF).
- ALU decode applies only in EXECUTER and EXECUTEI, keyed on Funct[4:1]:
  - 0100 ADD -> 00.
  - 0010 SUB -> 01.
  - 0000 AND -> 10.
  - 1100 ORR -> 11.
  - 1010 CMP -> 01 with NoWrite=1 and FlagW=11.
  - Any other command -> ADD, FlagW=00.
- Non-CMP flag writes: FlagW[1]=Funct[0]; FlagW[0]=Funct[0] & (ALUControl is ADD or SUB).
- Outside the execute states: ALUControl=00, FlagW=00, NoWrite=0.
- NoWrite is held for CMP in both EXECUTE and ALUWB, because the register write is suppressed downstream.
- Latency (cycles, including FETCH):
  - LDR 5, STR 4.
  - Data-processing 4.
  - Branch 3.
  - Illegal opcode 2.
- Reset asserted mid-instruction aborts it; no further write requests until the next instruction completes.

Test Plan:
- Reset: assert reset mid-MEMWR -> MemW drops to 0 in the same cycle. After release, IRWrite=1 and NextPC=1; the next cycle is DECODE with IRWrite=0.
- LDR (Op=01, Funct=011001): states FETCH, DECODE, MEMADR, MEMRD, MEMWB. RegW=1 only in the 5th cycle, with ResultSrc=01. Repeat with Rd=15 -> PCS=1 in that cycle.
- STR (Op=01, Funct=011000): MemW=1 with AdrSrc=1 only in cycle 4; RegW=0 throughout. Back to FETCH in cycle 5.
- ADDS register (Op=00, Funct=001001): EXECUTER with ALUControl=00, FlagW=11, then ALUWB with RegW=1. ORR without S (Funct=011000) -> FlagW=00, ALUControl=11.
- CMP immediate (Op=00, Funct=110101): EXECUTEI with ALUControl=01, FlagW=11, NoWrite=1, ALUSrcB=01.
- Branch (Op=10): BRANCH cycle with PCS=1, ALUSrcB=01, ResultSrc=10. Illegal Op=11 -> DECODE returns to FETCH with all writes 0.
